// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
//
// Holds the FSM state enum, RV32I funct3 width/sign codes and the default
// watchdog limit. No ports.

package lsu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane alignment, load extraction and legality
//
// Ports:
//   is_load, is_store, funct3, addr, wdata : incoming request (legality, store lanes)
//   legal      : request is a well-formed, naturally aligned access
//   be         : byte enables for the word access
//   lane_wdata : store data replicated onto the addressed lanes
//   ld_funct3, ld_offset, mem_rdata : captured load kind/offset and read word
//   load_data  : extracted and extended load result

module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] mem_rdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    legal      = 1'b0;
    be         = 4'b1111;
    lane_wdata = 32'h0;
    // Exactly one of load/store must be requested.
    if (is_load ^ is_store) begin
      if (is_load) begin
        case (funct3)
          LB, LBU: legal = 1'b1;
          LH, LHU: legal = ~addr[0];
          LW:      legal = (addr[1:0] == 2'b00);
          default: legal = 1'b0;
        endcase
      end else begin
        case (funct3)
          SB: begin
            legal      = 1'b1;
            be         = 4'b0001 << addr[1:0];
            lane_wdata = {4{wdata[7:0]}};
          end
          SH: begin
            legal      = ~addr[0];
            be         = addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata[15:0]}};
          end
          SW: begin
            legal      = (addr[1:0] == 2'b00);
            lane_wdata = wdata;
          end
          default: legal = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    ld_byte = mem_rdata[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_funct3)
      LB:      load_data = {{24{ld_byte[7]}}, ld_byte};
      LBU:     load_data = {24'h0, ld_byte};
      LH:      load_data = {{16{ld_half[15]}}, ld_half};
      LHU:     load_data = {16'h0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with watchdog
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   start, is_load, is_store  : request strobe (sampled in IDLE) and kind
//   funct3, addr, wdata       : width/sign code, byte address, store data
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata : registered memory request
//   mem_rdata, mem_ready      : read word and completion from memory
//   rdata, done, busy, fault  : load result, completion pulse, busy, error pulse

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        fault
);

  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wd_cnt;
  logic [2:0]  req_funct3;
  logic [1:0]  req_offset;
  logic        req_load;

  logic        legal;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  lsu_align u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .ld_funct3  (req_funct3),
    .ld_offset  (req_offset),
    .mem_rdata  (mem_rdata),
    .legal      (legal),
    .be         (be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  assign busy = (state == ACCESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wd_cnt     <= 8'd0;
      req_funct3 <= 3'b000;
      req_offset <= 2'b00;
      req_load   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
      rdata      <= 32'h0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              state      <= ACCESS;
              wd_cnt     <= 8'd0;
              req_funct3 <= funct3;
              req_offset <= addr[1:0];
              req_load   <= is_load;
              mem_req    <= 1'b1;
              mem_we     <= is_store;
              mem_addr   <= {addr[31:2], 2'b00};
              mem_be     <= be;
              mem_wdata  <= lane_wdata;
            end else begin
              fault <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // mem_ready is checked first so it wins on the expiry cycle.
          if (mem_ready || (wd_cnt == LAST_CYCLE)) begin
            state     <= IDLE;
            wd_cnt    <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            if (mem_ready) begin
              done <= 1'b1;
              if (req_load) rdata <= load_data;
            end else begin
              fault <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit

module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] rdata;
  logic        done, busy, fault;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rdata(rdata), .done(done), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          is_done;
    logic [31:0] rdata;
    int          req_cycles;
  } out_t;

  req_t req_q[$];
  out_t out_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit ok;
    int nbytes;
    if (ld == st) return 1'b0;
    if (ld) ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2});
    nbytes = 1 << f3[1:0];
    return ok && ((a % nbytes) == 0);
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 4'hF;
    case (f3[1:0])
      2'd0:    return 4'(1 << (a % 4));
      2'd1:    return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return (wd & 32'hFF) * 32'h01010101;
      2'd1:    return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int b;
    v = rd >> (8 * (a % 4));
    case (f3)
      3'd0: begin b = int'(v & 32'hFF);   if (b > 127)   b -= 256;   return 32'(b); end
      3'd4: return v & 32'hFF;
      3'd1: begin b = int'(v & 32'hFFFF); if (b > 32767) b -= 65536; return 32'(b); end
      3'd5: return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge of the done/fault cycle so the
  // next request can be issued back-to-back.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input logic [31:0] rd);
    bit   lg;
    int   k;
    req_t r;
    out_t o;
    lg = m_legal(ld, st, f3, a);
    mem_ready = 1'($urandom_range(0, 1));   // ignored while IDLE
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    if (lg) begin
      r.addr = a & 32'hFFFF_FFFC; r.be = m_be(st, f3, a); r.we = st; r.wdata = m_wdata(f3, wd);
      req_q.push_back(r);
      if (lat < TO) begin
        if (ld) model_rdata = m_load(f3, a, rd);
        o.is_done = 1'b1; o.req_cycles = lat + 1;
      end else begin
        o.is_done = 1'b0; o.req_cycles = TO;
      end
    end else begin
      o.is_done = 1'b0; o.req_cycles = 0;
    end
    o.rdata = model_rdata;
    out_q.push_back(o);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    k = 0;
    forever begin
      if (done || fault) break;
      if (k > 10) begin
        n_cmp++; n_fail++;
        $display("FAIL completion_wait: no done/fault after %0d cycles, expected one", k);
        break;
      end
      mem_ready = lg && (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  // ---------------- monitor ----------------
  bit          prev_req = 1'b0;
  int          req_cnt = 0;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_be;
  logic        h_we;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      req_cnt = 0;
    end else begin
      if (mem_req) begin
        if (!prev_req) begin
          if (req_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_mem_req: got mem_req=1 addr %h, expected none", mem_addr);
          end else begin
            req_t e;
            e = req_q.pop_front();
            check("mem_addr", mem_addr, e.addr);
            check("mem_be", 32'(mem_be), 32'(e.be));
            check("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          end
          h_addr = mem_addr; h_be = mem_be; h_we = mem_we; h_wdata = mem_wdata;
        end else begin
          check("stable_addr", mem_addr, h_addr);
          check("stable_be_we", {27'h0, h_we, mem_be}, {27'h0, mem_we, h_be});
          check("stable_wdata", mem_wdata, h_wdata);
        end
        check("busy_in_access", 32'(busy), 32'd1);
        req_cnt++;
      end
      prev_req = mem_req;
      if (done || fault) begin
        if (out_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_outcome: got done=%0d fault=%0d, expected none", done, fault);
        end else begin
          out_t e;
          e = out_q.pop_front();
          check("done", 32'(done), 32'(e.is_done));
          check("fault", 32'(fault), 32'(!e.is_done));
          check("rdata", rdata, e.rdata);
          check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
          check("not_busy_at_outcome", 32'(busy), 32'd0);
        end
        req_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    req_t r;
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {29'h0, done, busy, fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(1'b0, 1'b1, SW, 32'h1000, 32'hCAFEBABE, 2, 32'h0);
    issue(1'b1, 1'b0, LB, 32'h2003, 32'h0, 0, 32'h80FF0011);
    issue(1'b1, 1'b0, LBU, 32'h2003, 32'h0, 1, 32'h80FF0011);
    issue(1'b0, 1'b1, SH, 32'h2002, 32'h00001234, 0, 32'h0);
    issue(1'b1, 1'b0, LH, 32'h2001, 32'h0, 0, 32'h0);
    issue(1'b1, 1'b0, LW, 32'h3000, 32'h0, 9, 32'h0);          // watchdog expiry
    issue(1'b1, 1'b0, LW, 32'h3004, 32'h0, TO - 1, 32'h13572468); // ready on expiry cycle
    issue(1'b1, 1'b1, LW, 32'h3008, 32'h0, 0, 32'h0);          // both kinds -> fault
    issue(1'b1, 1'b0, LHU, 32'h300A, 32'h0, 0, 32'hBEEF0000);  // accepted in fault cycle

    // Reset in the middle of an access
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h40;
    r.addr = 32'h40; r.be = 4'hF; r.we = 1'b0; r.wdata = 32'h0;
    req_q.push_back(r);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_mem_req", 32'(mem_req), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    check("rst_rdata_cleared", rdata, 32'h0);
    issue(1'b1, 1'b0, LW, 32'h0, 32'h0, 1, 32'h0BADF00D);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      int kind;
      bit ld, st;
      kind = int'($urandom_range(0, 9));
      ld = (kind == 0) || (kind >= 2 && kind <= 5);
      st = (kind == 0) || (kind >= 6);
      issue(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
            int'($urandom_range(0, 5)), $urandom);
    end

    repeat (3) @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("out_q_drained", 32'(out_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
